// File: rtl/countdown_timer_dp.sv
// Countdown-timer datapath: loads hh:mm:ss, counts down in hh:mm:ss.cc steps
// to zero and flags expiry. Produces the same msec/sec/min/hour bus as the
// stopwatch datapath so both can share the display path.
module countdown_timer_dp #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_runstop,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [4:0] i_load_hour,
    input  logic [5:0] i_load_min,
    input  logic [5:0] i_load_sec,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       o_done,
    output logic       o_expired
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [4:0]    ld_hour;
    logic [5:0]    ld_min;
    logic [5:0]    ld_sec;
    logic          ld_nonzero;
    logic          last_cs;

    // Clamp the preset fields to legal clock ranges and note whether the preset is zero
    always_comb begin
        ld_hour    = (i_load_hour > 5'd23) ? 5'd23 : i_load_hour;
        ld_min     = (i_load_min  > 6'd59) ? 6'd59 : i_load_min;
        ld_sec     = (i_load_sec  > 6'd59) ? 6'd59 : i_load_sec;
        ld_nonzero = (ld_hour != 5'd0) || (ld_min != 6'd0) || (ld_sec != 6'd0);
    end

    // Detect 00:00:00.01, the last value before the count reaches zero
    always_comb begin
        last_cs = (hour == 5'd0) && (min == 6'd0) && (sec == 6'd0) && (msec == 7'd1);
    end

    // State, prescaler and time registers; clear beats load, load beats run logic
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            presc  <= '0;
            msec   <= 7'd0;
            sec    <= 6'd0;
            min    <= 6'd0;
            hour   <= 5'd0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_clear) begin
                state <= ST_IDLE;
                presc <= '0;
                msec  <= 7'd0;
                sec   <= 6'd0;
                min   <= 6'd0;
                hour  <= 5'd0;
            end else if (i_load && (state != ST_RUN)) begin
                state <= ld_nonzero ? ST_ARMED : ST_IDLE;
                presc <= '0;
                msec  <= 7'd0;
                sec   <= ld_sec;
                min   <= ld_min;
                hour  <= ld_hour;
            end else begin
                case (state)
                    ST_ARMED: begin
                        if (i_runstop) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!i_runstop) begin
                            state <= ST_ARMED;
                        end else if (presc == PRESC_LAST) begin
                            presc <= '0;
                            if (last_cs) begin
                                state  <= ST_DONE;
                                o_done <= 1'b1;
                            end
                            if (msec != 7'd0) begin
                                msec <= msec - 7'd1;
                            end else begin
                                msec <= 7'd99;
                                if (sec != 6'd0) begin
                                    sec <= sec - 6'd1;
                                end else begin
                                    sec <= 6'd59;
                                    if (min != 6'd0) begin
                                        min <= min - 6'd1;
                                    end else begin
                                        min  <= 6'd59;
                                        hour <= hour - 5'd1;
                                    end
                                end
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_expired = (state == ST_DONE);

endmodule

// File: tb/tb_countdown_timer_dp.sv
// Testbench for countdown_timer_dp: directed scenarios and random stimulus,
// each cycle compared against a model that tracks the remaining time as a
// single centisecond count.
module tb_countdown_timer_dp;

    localparam int TICK_DIV = 4;

    logic       clk;
    logic       rst;
    logic       i_runstop;
    logic       i_clear;
    logic       i_load;
    logic [4:0] i_load_hour;
    logic [5:0] i_load_min;
    logic [5:0] i_load_sec;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       o_done;
    logic       o_expired;

    typedef enum int {M_IDLE, M_ARMED, M_RUN, M_DONE} mode_t;

    int    m_cs;
    int    m_phase;
    mode_t m_mode;
    logic  m_done;

    int n_checks;
    int n_pass;

    countdown_timer_dp #(.CLK_FREQ(400), .TICK_HZ(100)) dut (
        .clk(clk), .rst(rst), .i_runstop(i_runstop), .i_clear(i_clear),
        .i_load(i_load), .i_load_hour(i_load_hour), .i_load_min(i_load_min),
        .i_load_sec(i_load_sec), .msec(msec), .sec(sec), .min(min), .hour(hour),
        .o_done(o_done), .o_expired(o_expired)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: remaining time as total centiseconds
    task automatic model_update();
        int h, mi, s;
        m_done = 1'b0;
        if (rst) begin
            m_cs = 0; m_phase = 0; m_mode = M_IDLE;
        end else if (i_clear) begin
            m_cs = 0; m_phase = 0; m_mode = M_IDLE;
        end else if (i_load && m_mode != M_RUN) begin
            h  = (i_load_hour > 23) ? 23 : int'(i_load_hour);
            mi = (i_load_min  > 59) ? 59 : int'(i_load_min);
            s  = (i_load_sec  > 59) ? 59 : int'(i_load_sec);
            m_cs = ((h * 60 + mi) * 60 + s) * 100;
            m_phase = 0;
            m_mode = (m_cs != 0) ? M_ARMED : M_IDLE;
        end else if (m_mode == M_ARMED) begin
            if (i_runstop) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!i_runstop) begin
                m_mode = M_ARMED;
            end else begin
                m_phase++;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    m_cs--;
                    if (m_cs == 0) begin
                        m_mode = M_DONE;
                        m_done = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [25:0] model_vec();
        return {5'(m_cs / 360000), 6'((m_cs / 6000) % 60), 6'((m_cs / 100) % 60),
                7'(m_cs % 100), m_done, (m_mode == M_DONE)};
    endfunction

    function automatic logic [25:0] dut_vec();
        return {hour, min, sec, msec, o_done, o_expired};
    endfunction

    // Advance one clock edge, update the model, then settle past the edge
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_load(input logic l, input int h, input int mi, input int s);
        i_load      = l;
        i_load_hour = 5'(h);
        i_load_min  = 6'(mi);
        i_load_sec  = 6'(s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (dut_vec() !== 26'd0) $display("[TB] FAIL reset: got %h expected %h", dut_vec(), 26'd0);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_expiry();
        int done_count = 0;
        for (int c = 0; c < 430; c++) begin
            set_load(c == 0, 0, 0, 1);
            i_runstop = 1'b1;
            step();
            if (o_done === 1'b1) done_count++;
            n_checks++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL expiry c%0d: got %h expected %h", c, dut_vec(), model_vec());
            else n_pass++;
            if (c == 401) begin
                n_checks++;
                if ({o_done, o_expired, msec} !== {1'b1, 1'b1, 7'd0}) $display("[TB] FAIL expiry_edge: got %b expected %b", {o_done, o_expired, msec}, {1'b1, 1'b1, 7'd0});
                else n_pass++;
            end
        end
        n_checks++;
        if ({done_count, o_expired, dut_vec()} !== {32'd1, 1'b1, 26'h1}) $display("[TB] FAIL expiry_hold: got pulses %0d vec %h expected 1 and %h", done_count, dut_vec(), 26'h1);
        else n_pass++;
    endtask

    task automatic test_borrow();
        for (int c = 0; c < 8; c++) begin
            set_load(c == 0, 1, 0, 0);
            i_runstop = 1'b1;
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL borrow c%0d: got %h expected %h", c, dut_vec(), model_vec());
            else n_pass++;
            if (c == 5) begin
                n_checks++;
                if ({hour, min, sec, msec} !== {5'd0, 6'd59, 6'd59, 7'd99}) $display("[TB] FAIL borrow_chain: got %0d:%0d:%0d.%0d expected 0:59:59.99", hour, min, sec, msec);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clamp();
        i_runstop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_clear = (c == 0);
            set_load(c == 1, 31, 60, 63);
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL clamp c%0d: got %h expected %h", c, dut_vec(), model_vec());
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd0}) $display("[TB] FAIL clamp_value: got %0d:%0d:%0d.%0d expected 23:59:59.0", hour, min, sec, msec);
                else n_pass++;
            end
        end
        i_clear = 1'b0;
        set_load(1'b0, 0, 0, 0);
    endtask

    task automatic test_pause();
        for (int c = 0; c < 20; c++) begin
            set_load(c == 0, 0, 0, 5);
            if (c == 17) set_load(1'b1, 0, 10, 0);
            i_runstop = (c >= 1 && c <= 3) || (c >= 14);
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL pause c%0d: got %h expected %h", c, dut_vec(), model_vec());
            else n_pass++;
            if (c == 15 || c == 16 || c == 17) begin
                n_checks++;
                if (c == 15 && {min, sec, msec} !== {6'd0, 6'd5, 7'd0})
                    $display("[TB] FAIL pause_hold: got %0d.%0d expected 5.0", sec, msec);
                else if (c != 15 && {min, sec, msec} !== {6'd0, 6'd4, 7'd99})
                    $display("[TB] FAIL pause_resume c%0d: got %0d:%0d.%0d expected 0:4.99", c, min, sec, msec);
                else n_pass++;
            end
        end
        set_load(1'b0, 0, 0, 0);
    endtask

    task automatic test_clear();
        for (int c = 0; c < 14; c++) begin
            set_load(c == 0 || c == 11, 0, (c == 0) ? 1 : 0, 0);
            i_clear   = (c == 10);
            i_runstop = (c != 11);
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL clear c%0d: got %h expected %h", c, dut_vec(), model_vec());
            else n_pass++;
            if (c >= 10) begin
                n_checks++;
                if (dut_vec() !== 26'd0) $display("[TB] FAIL clear_zero c%0d: got %h expected 0", c, dut_vec());
                else n_pass++;
            end
        end
        i_clear = 1'b0;
        set_load(1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_and_reload();
        for (int c = 0; c < 441; c++) begin
            set_load(c == 0 || c == 23 || c == 430, 0, 0, (c == 0) ? 3 : ((c == 23) ? 1 : 2));
            rst       = (c == 21);
            i_runstop = (c != 22);
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL reload c%0d: got %h expected %h", c, dut_vec(), model_vec());
            else n_pass++;
            if (c == 21) begin
                n_checks++;
                if (dut_vec() !== 26'd0) $display("[TB] FAIL rst_midrun: got %h expected 0", dut_vec());
                else n_pass++;
            end
            if (c == 429 || c == 430) begin
                n_checks++;
                if (o_expired !== (c == 429)) $display("[TB] FAIL done_reload c%0d: got expired %b expected %b", c, o_expired, (c == 429));
                else n_pass++;
            end
            if (c == 435) begin
                n_checks++;
                if ({sec, msec} !== {6'd1, 7'd99}) $display("[TB] FAIL reload_run: got %0d.%0d expected 1.99", sec, msec);
                else n_pass++;
            end
        end
        rst = 1'b0;
        set_load(1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            i_clear = ($urandom_range(0, 149) == 0);
            i_load  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) begin
                i_load_hour = 5'($urandom_range(0, 31));
                i_load_min  = 6'($urandom_range(0, 63));
                i_load_sec  = 6'($urandom_range(0, 63));
            end else begin
                i_load_hour = 5'd0;
                i_load_min  = 6'd0;
                i_load_sec  = 6'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 39) == 0) i_runstop = ~i_runstop;
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL random c%0d: got %h expected %h", c, dut_vec(), model_vec());
            else n_pass++;
        end
        rst = 1'b0; i_clear = 1'b0;
        set_load(1'b0, 0, 0, 0);
    endtask

    // Run every scenario in order and report the tally
    initial begin
        n_checks = 0; n_pass = 0;
        m_cs = 0; m_phase = 0; m_mode = M_IDLE; m_done = 1'b0;
        rst = 1'b1; i_runstop = 1'b0; i_clear = 1'b0;
        set_load(1'b0, 0, 0, 0);
        test_reset();
        test_expiry();
        test_borrow();
        test_clamp();
        test_pause();
        test_clear();
        test_reset_and_reload();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
